vga_stream_display: RTL and testbench

VGA_STREAM_DISPLAY -- requirements
Module: vga_stream_display

---
 rtl/vga_stream_display.sv | 174 +++++++++++++++++
 tb/tb_vga_stream_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_display.sv
// Streams RGB565 pixels from a valid/ready source onto VGA raster timing; optional macro VGA_UNDERFLOW_COUNT_EN builds the underflow event counter.
// Latency: all vga_* outputs are registered one clock after the raster position that produces them.
// Backpressure: in_ready is high on active cycles when locked; when seeking, non-SOP pixels are drained and an SOP pixel is held until raster (0,0).
module vga_stream_display #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    output logic [15:0] vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_valid,
    output logic        underflow,
    output logic [15:0] underflow_count
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SL   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SL   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [0:0] {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [15:0]     rgb_q, rgb_d;
    logic            hs_q, vs_q, vld_q;
    logic            uf_q;
    logic            rdy_en_q;
    logic            rdy_raw;
    logic            uf_ev;
    logic            active;
    logic            at_origin;

    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign at_origin = (h_q == '0) && (v_q == '0);

    // Raster position: h wraps at end of line, v advances on each h wrap.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Lock FSM: decides ready, pixel to show and whether this cycle is an underflow event.
    always_comb begin
        state_d = state_q;
        rdy_raw = 1'b0;
        rgb_d   = 16'h0000;
        uf_ev   = 1'b0;
        unique case (state_q)
            SEEK: begin
                // Drain stray pixels; park an SOP pixel until the raster reaches (0,0).
                rdy_raw = ~in_sop | at_origin;
                if (rdy_en_q && in_valid && in_sop && at_origin) begin
                    state_d = LOCKED;
                    rgb_d   = in_data;
                end
            end
            LOCKED: begin
                if (active) begin
                    // A misplaced SOP is left on the bus so it can align to the next frame.
                    rdy_raw = ~(in_valid & in_sop & ~at_origin);
                    if (!in_valid || (in_sop != at_origin)) begin
                        uf_ev   = 1'b1;
                        state_d = SEEK;
                    end else begin
                        rgb_d = in_data;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    assign in_ready = rdy_raw & rdy_en_q;

    // State register plus ready enable that keeps in_ready low until the first clock out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= SEEK;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Registered video outputs, all derived from the same raster position so they stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q <= 16'h0000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= ~((h_q >= H_SS) && (h_q <= H_SL));
            vs_q  <= ~((v_q >= V_SS) && (v_q <= V_SL));
            vld_q <= active;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uf_q <= 1'b0;
        end else if (uf_ev) begin
            uf_q <= 1'b1;
        end
    end

`ifdef VGA_UNDERFLOW_COUNT_EN
    logic [15:0] cnt_q;

    // Underflow event counter, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else if (uf_ev && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign underflow_count = cnt_q;
`else
    assign underflow_count = 16'h0000;
`endif

    assign vga_rgb   = rgb_q;
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;
    assign vga_valid = vld_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_vga_stream_display.sv
// Bench for vga_stream_display on a 15x8 raster (8x4 active).
// Expected outputs are queued when inputs are driven and compared one clock later.
module tb_vga_stream_display;

`ifdef VGA_UNDERFLOW_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    localparam int HT = 15;
    localparam int FT = 120;

    logic        clock;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_ready;
    logic [15:0] vga_rgb;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_valid;
    logic        underflow;
    logic [15:0] underflow_count;

    vga_stream_display #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sop(in_sop),
        .in_ready(in_ready),
        .vga_rgb(vga_rgb),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_valid(vga_valid),
        .underflow(underflow),
        .underflow_count(underflow_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        vld;
    } exp_t;

    typedef struct {
        int   pos;
        logic hs;
        logic vs;
        logic vld;
    } tv_t;

    exp_t sb[$];
    tv_t  tv[17];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pos    = 0;
    logic hs_log[FT];
    logic vs_log[FT];
    logic vld_log[FT];
    int   nz_rgb;

    function automatic logic is_act(input int p);
        return ((p % HT) < 8) && ((p / HT) < 4);
    endfunction

    function automatic logic hs_low(input int p);
        return ((p % HT) >= 10) && ((p % HT) <= 12);
    endfunction

    function automatic logic vs_low(input int p);
        return ((p / HT) >= 5) && ((p / HT) <= 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @pos %0d: got %h, expected %h", name, pos, act, exp);
    endtask

    // One raster cycle: drive, check ready, queue expected output, clock, compare.
    task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                       input logic er, input logic [15:0] ergb);
        exp_t e;
        in_valid = v;
        in_sop   = s;
        in_data  = d;
        #1;
        chk("in_ready", 32'(in_ready), 32'(er));
        e.rgb = ergb;
        e.hs  = ~hs_low(pos);
        e.vs  = ~vs_low(pos);
        e.vld = is_act(pos);
        sb.push_back(e);
        @(posedge clock);
        #1;
        pos = (pos + 1) % FT;
        e = sb.pop_front();
        chk("vga_rgb",   32'(vga_rgb),   32'(e.rgb));
        chk("vga_hsync", 32'(vga_hsync), 32'(e.hs));
        chk("vga_vsync", 32'(vga_vsync), 32'(e.vs));
        chk("vga_valid", 32'(vga_valid), 32'(e.vld));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),        32'(0));
        chk({tag, "_rgb"},       32'(vga_rgb),         32'(0));
        chk({tag, "_hsync"},     32'(vga_hsync),       32'(1));
        chk({tag, "_vsync"},     32'(vga_vsync),       32'(1));
        chk({tag, "_valid"},     32'(vga_valid),       32'(0));
        chk({tag, "_underflow"}, 32'(underflow),       32'(0));
        chk({tag, "_count"},     32'(underflow_count), 32'(0));
    endtask

    // One frame starting at raster (0,0) from a source streaming base+i with SOP on pixel 0.
    // drop_at / mis_at: active pixel index where valid drops or the next frame's SOP appears early.
    task automatic frame(input logic [15:0] base, input int drop_at, input int mis_at,
                         input logic [15:0] nb);
        int i;
        bit broken;
        i = 0;
        broken = 1'b0;
        for (int p = 0; p < FT; p++) begin
            if (broken) begin
                cyc(1'b1, 1'b1, nb, 1'b0, 16'h0000);
            end else if (is_act(pos)) begin
                if (i == drop_at) begin
                    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
                    broken = 1'b1;
                end else if (i == mis_at) begin
                    cyc(1'b1, 1'b1, nb, 1'b0, 16'h0000);
                    broken = 1'b1;
                end else begin
                    cyc(1'b1, (i == 0), base + 16'(i), 1'b1, base + 16'(i));
                    i++;
                end
            end else if (i == 32) begin
                cyc(1'b1, 1'b1, nb, 1'b0, 16'h0000);
            end else begin
                cyc(1'b1, 1'b0, base + 16'(i), 1'b0, 16'h0000);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int run, best, hs_n, vs_n, vld_n;

        // Raster-position timing vectors: {pos, hsync, vsync, valid}.
        tv[0]  = '{0,   1'b1, 1'b1, 1'b1};
        tv[1]  = '{7,   1'b1, 1'b1, 1'b1};
        tv[2]  = '{8,   1'b1, 1'b1, 1'b0};
        tv[3]  = '{9,   1'b1, 1'b1, 1'b0};
        tv[4]  = '{10,  1'b0, 1'b1, 1'b0};
        tv[5]  = '{12,  1'b0, 1'b1, 1'b0};
        tv[6]  = '{13,  1'b1, 1'b1, 1'b0};
        tv[7]  = '{14,  1'b1, 1'b1, 1'b0};
        tv[8]  = '{15,  1'b1, 1'b1, 1'b1};
        tv[9]  = '{52,  1'b1, 1'b1, 1'b1};
        tv[10] = '{60,  1'b1, 1'b1, 1'b0};
        tv[11] = '{74,  1'b1, 1'b1, 1'b0};
        tv[12] = '{75,  1'b1, 1'b0, 1'b0};
        tv[13] = '{85,  1'b0, 1'b0, 1'b0};
        tv[14] = '{104, 1'b1, 1'b0, 1'b0};
        tv[15] = '{105, 1'b1, 1'b1, 1'b0};
        tv[16] = '{119, 1'b1, 1'b1, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 16'hFFFF;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_checks("rst");
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        pos   = 0;

        // Idle frame: raster timing only; ready held low until the first clock after reset.
        nz_rgb = 0;
        for (int p = 0; p < FT; p++) begin
            cyc(1'b0, 1'b0, 16'h0000, (p != 0), 16'h0000);
            hs_log[p]  = vga_hsync;
            vs_log[p]  = vga_vsync;
            vld_log[p] = vga_valid;
            if (vga_rgb != 16'h0000) nz_rgb++;
        end
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("tbl_hs_%0d", tv[k].pos),  32'(hs_log[tv[k].pos]),  32'(tv[k].hs));
            chk($sformatf("tbl_vs_%0d", tv[k].pos),  32'(vs_log[tv[k].pos]),  32'(tv[k].vs));
            chk($sformatf("tbl_vld_%0d", tv[k].pos), 32'(vld_log[tv[k].pos]), 32'(tv[k].vld));
        end
        hs_n = 0; vs_n = 0; vld_n = 0; run = 0; best = 0;
        for (int p = 0; p < FT; p++) begin
            if (!hs_log[p]) hs_n++;
            if (vld_log[p]) vld_n++;
            if (!vs_log[p]) begin
                vs_n++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        chk("hsync_low_cycles", 32'(hs_n), 32'(24));
        chk("vsync_low_cycles", 32'(vs_n), 32'(30));
        chk("vsync_low_run",    32'(best), 32'(30));
        chk("valid_cycles",     32'(vld_n), 32'(32));
        chk("idle_rgb_nonzero", 32'(nz_rgb), 32'(0));

        // Lock: SOP 0x1234 presented mid-frame, held off until (0,0).
        for (int p = 0; p < 50; p++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        for (int p = 50; p < FT; p++) cyc(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000);
        frame(16'h1234, -1, -1, 16'h2000);
        chk("lock_underflow", 32'(underflow),       32'(0));
        chk("lock_count",     32'(underflow_count), 32'(0));

        // Underflow: valid dropped at pixel 5; next SOP waits for the following frame.
        frame(16'h2000, 5, -1, 16'h3000);
        chk("drop_underflow", 32'(underflow),       32'(1));
        chk("drop_count",     32'(underflow_count), 32'(CNT_EN ? 1 : 0));

        // Relock, then misaligned SOP at pixel 10; that pixel shows at the next (0,0).
        frame(16'h3000, -1, 10, 16'h4000);
        chk("mis_underflow", 32'(underflow),       32'(1));
        chk("mis_count",     32'(underflow_count), 32'(CNT_EN ? 2 : 0));

        frame(16'h4000, 3, -1, 16'h5000);
        chk("third_underflow", 32'(underflow),       32'(1));
        chk("third_count",     32'(underflow_count), 32'(CNT_EN ? 3 : 0));

        // Reset mid-line while locked and streaming.
        cyc(1'b1, 1'b1, 16'h5000, 1'b1, 16'h5000);
        for (int p = 1; p < 4; p++) cyc(1'b1, 1'b0, 16'h5000 + 16'(p), 1'b1, 16'h5000 + 16'(p));
        in_valid = 1'b0;
        in_sop   = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        reset_checks("midrst");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        pos   = 0;
        sb.delete();
        for (int p = 0; p < 20; p++) cyc(1'b0, 1'b0, 16'h0000, (p != 0), 16'h0000);
        chk("post_rst_underflow", 32'(underflow),       32'(0));
        chk("post_rst_count",     32'(underflow_count), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
